// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory image loader.
package imem_loader_pkg;
    typedef enum logic [2:0] {
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam int LEN_BYTES      = 4;
    localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/imem_loader_assembler.sv
// Collects little-endian bytes into 32-bit words; word_valid fires on the 4th accepted byte.
module byte_word_assembler
    import imem_loader_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic [7:0]  i_byte,
    output logic        o_word_valid,
    output logic [31:0] o_word
);
    // Only the first three bytes need storage; the fourth is taken straight from the input.
    logic [23:0] r_shift;
    logic [1:0]  r_cnt;

    assign o_word_valid = i_en && (r_cnt == 2'(BYTES_PER_WORD - 1));
    assign o_word       = {i_byte, r_shift};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_clr) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_en) begin
            r_shift <= {i_byte, r_shift[23:8]};
            r_cnt   <= r_cnt + 2'd1;
        end
    end
endmodule

// File: rtl/imem_loader.sv
// Receives a length/payload/checksum byte frame and writes it into the instruction store,
// holding the CPU until a verified image is present.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_WORDS  = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_in_valid,
    input  logic [7:0]            i_in_data,
    output logic                  o_in_ready,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [31:0]           o_mem_wdata,
    output logic                  o_cpu_hold,
    output logic                  o_done,
    output logic                  o_error
);
    localparam int WCW = $clog2(MAX_WORDS + 1);

    if (LEN_BYTES != BYTES_PER_WORD) begin : g_chk_len
        $error("length field and payload words must share the assembler width");
    end
    if (MAX_WORDS > (1 << ADDR_WIDTH)) begin : g_chk_max
        $error("MAX_WORDS exceeds instruction store depth");
    end

    state_t          r_state;
    logic            r_in_ready;
    logic            r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [31:0]     r_mem_wdata;
    logic            r_cpu_hold;
    logic            r_done;
    logic            r_error;
    logic [WCW-1:0]  r_len;
    logic [WCW-1:0]  r_wcnt;
    logic [7:0]      r_sum;

    logic            w_hs;
    logic            w_asm_en;
    logic            w_rearm;
    logic            w_word_valid;
    logic [31:0]     w_word;

    assign w_hs     = i_in_valid && r_in_ready;
    assign w_asm_en = w_hs && (r_state == ST_LEN || r_state == ST_DATA);
    assign w_rearm  = i_start && (r_state == ST_DONE || r_state == ST_ERROR);

    byte_word_assembler u_asm (
        .i_clk        (i_clk),
        .i_rst        (i_reset),
        .i_clr        (w_rearm),
        .i_en         (w_asm_en),
        .i_byte       (i_in_data),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_LEN;
            r_in_ready  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_hold  <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_len       <= '0;
            r_wcnt      <= '0;
            r_sum       <= '0;
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                ST_LEN: begin
                    r_in_ready <= 1'b1;
                    if (w_word_valid) begin
                        if (w_word > 32'(MAX_WORDS)) begin
                            r_state    <= ST_ERROR;
                            r_in_ready <= 1'b0;
                            r_error    <= 1'b1;
                        end else if (w_word == 32'd0) begin
                            r_state <= ST_CSUM;
                        end else begin
                            r_len   <= w_word[WCW-1:0];
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_hs)
                        r_sum <= r_sum + i_in_data;
                    if (w_word_valid) begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= ADDR_WIDTH'(r_wcnt);
                        r_mem_wdata <= w_word;
                        r_wcnt      <= r_wcnt + 1'b1;
                        if (r_wcnt == r_len - 1'b1)
                            r_state <= ST_CSUM;
                    end
                end
                ST_CSUM: begin
                    if (w_hs) begin
                        r_in_ready <= 1'b0;
                        if (i_in_data == r_sum) begin
                            r_state    <= ST_DONE;
                            r_done     <= 1'b1;
                            r_cpu_hold <= 1'b0;
                        end else begin
                            r_state <= ST_ERROR;
                            r_error <= 1'b1;
                        end
                    end
                end
                default: begin
                    // DONE / ERROR: parked until re-armed; stored words stay as written
                    if (i_start) begin
                        r_state    <= ST_LEN;
                        r_in_ready <= 1'b1;
                        r_cpu_hold <= 1'b1;
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                        r_len      <= '0;
                        r_wcnt     <= '0;
                        r_sum      <= '0;
                    end
                end
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_cpu_hold  = r_cpu_hold;
    assign o_done      = r_done;
    assign o_error     = r_error;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of per-cycle vectors plus random-valid and reset-mid-frame sequences.
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        vld;
    logic [7:0]  data;
    logic        ready, we, hold, done, err;
    logic [9:0]  addr;
    logic [31:0] wdata;

    int errors = 0;
    int checks = 0;

    imem_loader #(.ADDR_WIDTH(10), .MAX_WORDS(1024)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_start     (start),
        .i_in_valid  (vld),
        .i_in_data   (data),
        .o_in_ready  (ready),
        .o_mem_we    (we),
        .o_mem_addr  (addr),
        .o_mem_wdata (wdata),
        .o_cpu_hold  (hold),
        .o_done      (done),
        .o_error     (err)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] W0 = 32'h00500093;
    localparam logic [31:0] W1 = 32'h00100113;
    // expected status modes: busy (ready, held), done, error
    localparam int B = 0, D = 1, E = 2;

    typedef struct {
        logic        st;
        logic        vl;
        logic [7:0]  d;
        logic        we;
        logic [9:0]  a;
        logic [31:0] w;
        int          m;
    } vec_t;
    vec_t tv[$];

    task automatic add(input logic st, input logic vl, input logic [7:0] d,
                       input logic xwe, input logic [9:0] xa, input logic [31:0] xw, input int m);
        vec_t v;
        v.st = st; v.vl = vl; v.d = d; v.we = xwe; v.a = xa; v.w = xw; v.m = m;
        tv.push_back(v);
    endtask

    // N=2 frame of W0,W1; payload sum is 0x07. Starts with the store showing (1, W1) or reset (0, 0).
    task automatic add_frame2(input logic [7:0] cs, input logic [9:0] pa, input logic [31:0] pw,
                              input int endm);
        add(0, 1, 8'h02, 0, pa, pw, B);
        add(0, 1, 8'h00, 0, pa, pw, B);
        add(0, 1, 8'h00, 0, pa, pw, B);
        add(0, 1, 8'h00, 0, pa, pw, B);
        add(0, 1, 8'h93, 0, pa, pw, B);
        add(0, 0, 8'hA5, 0, pa, pw, B);
        add(0, 1, 8'h00, 0, pa, pw, B);
        add(0, 1, 8'h50, 0, pa, pw, B);
        add(0, 1, 8'h00, 1, 0, W0, B);
        add(0, 1, 8'h13, 0, 0, W0, B);
        add(0, 1, 8'h01, 0, 0, W0, B);
        add(0, 1, 8'h10, 0, 0, W0, B);
        add(0, 1, 8'h00, 1, 1, W1, B);
        add(0, 0, 8'h07, 0, 1, W1, B);
        add(0, 1, cs,    0, 1, W1, endm);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] mode_bits(input int m);
        // {ready, hold, done, error}
        case (m)
            D:       return 4'b0010;
            E:       return 4'b0101;
            default: return 4'b1100;
        endcase
    endfunction

    task automatic cycle(input logic st, input logic vl, input logic [7:0] d);
        @(negedge clk);
        start = st; vld = vl; data = d;
        @(posedge clk);
        #1;
    endtask

    int wcnt;
    logic [9:0]  waddr;
    logic [31:0] wword;

    initial begin
        logic [7:0] fr1 [9];
        logic [7:0] fr2 [9];
        int idx;
        int cyc;

        rst = 1'b1; start = 1'b0; vld = 1'b0; data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {we, addr, wdata, ready, hold, done, err},
              {1'b0, 10'd0, 32'd0, 4'b0100});
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        check("armed_after_reset", {ready, hold, done, err}, 4'b1100);

        // good frame, bad checksum (0x2E), re-armed good frame, oversize N, N=0
        add_frame2(8'h07, 0, 0, D);
        add(0, 1, 8'hFF, 0, 1, W1, D);
        add(1, 0, 8'h00, 0, 1, W1, B);
        add_frame2(8'h2E, 1, W1, E);
        add(0, 1, 8'h07, 0, 1, W1, E);
        add(1, 0, 8'h00, 0, 1, W1, B);
        add_frame2(8'h07, 1, W1, D);
        add(1, 0, 8'h00, 0, 1, W1, B);
        add(0, 1, 8'h01, 0, 1, W1, B);
        add(0, 1, 8'h04, 0, 1, W1, B);
        add(0, 1, 8'h00, 0, 1, W1, B);
        add(0, 1, 8'h00, 0, 1, W1, E);
        add(0, 1, 8'h00, 0, 1, W1, E);
        add(1, 0, 8'h00, 0, 1, W1, B);
        add(1, 0, 8'h00, 0, 1, W1, B);
        add(0, 1, 8'h00, 0, 1, W1, B);
        add(0, 1, 8'h00, 0, 1, W1, B);
        add(0, 1, 8'h00, 0, 1, W1, B);
        add(0, 1, 8'h00, 0, 1, W1, B);
        add(0, 1, 8'h00, 0, 1, W1, D);

        foreach (tv[i]) begin
            cycle(tv[i].st, tv[i].vl, tv[i].d);
            check($sformatf("vec%0d", i), {we, addr, wdata, ready, hold, done, err},
                  {tv[i].we, tv[i].a, tv[i].w, mode_bits(tv[i].m)});
        end

        // N=1, 0xDEADBEEF, randomly toggled valid; garbage on idle cycles must be ignored
        fr1 = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h38};
        cycle(1'b1, 1'b0, 8'h00);
        wcnt = 0; waddr = '1; wword = '0; idx = 0; cyc = 0;
        while (idx < 9 && cyc < 400) begin
            logic v;
            v = 1'(($urandom_range(0, 1)));
            cycle(1'b0, v, v ? fr1[idx] : 8'($urandom_range(0, 255)));
            if (v && idx < 9) idx++;
            if (we) begin wcnt++; waddr = addr; wword = wdata; end
            cyc++;
        end
        check("rand_frame_finished", 64'(idx), 64'd9);
        cycle(1'b0, 1'b0, 8'h00);
        if (we) wcnt++;
        check("rand_write_count", 64'(wcnt), 64'd1);
        check("rand_write", {waddr, wword}, {10'd0, 32'hDEADBEEF});
        check("rand_done", {ready, hold, done, err}, 4'b0010);

        // reset after two payload bytes, then a full N=1 frame of 0x44332211 (sum 0xAA)
        cycle(1'b1, 1'b0, 8'h00);
        wcnt = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b1, fr1[i]);
            if (we) wcnt++;
        end
        @(negedge clk);
        vld = 1'b0; rst = 1'b1;
        #1;
        check("midreset_state", {we, addr, wdata, ready, hold, done, err},
              {1'b0, 10'd0, 32'd0, 4'b0100});
        @(negedge clk) rst = 1'b0;
        cycle(1'b0, 1'b0, 8'h00);
        fr2 = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
        waddr = '1; wword = '0;
        for (int i = 0; i < 9; i++) begin
            cycle(1'b0, 1'b1, fr2[i]);
            if (we) begin wcnt++; waddr = addr; wword = wdata; end
        end
        check("midreset_write_count", 64'(wcnt), 64'd1);
        check("midreset_write", {waddr, wword}, {10'd0, 32'h44332211});
        check("midreset_done", {ready, hold, done, err}, 4'b0010);
        cycle(1'b0, 1'b0, 8'h00);
        check("midreset_no_extra_we", {63'd0, we}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
